// File: rtl/selector_pkg.sv
// Shared constants and helpers for registered channel selectors.
// Mode encodings and the selector/ID width rule live here.
package selector_pkg;

   localparam logic MODE_FIXED = 1'b0;
   localparam logic MODE_RR    = 1'b1;

   // Selector width for n channels; never below one bit.
   function automatic int sel_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/mux_n_arb_rr_pick.sv
// Combinational round-robin picker: first request at or above ptr.
// Rotate, isolate the lowest set bit, rotate back.
module rr_pick #(
   parameter int n  = 4,
   parameter int pw = 2
) (
   input  logic [n-1:0]  req,
   input  logic [pw-1:0] ptr,
   output logic [n-1:0]  gnt,
   output logic          found
);

   logic [2*n-1:0] dbl_req;
   logic [n-1:0]   rot;
   logic [n-1:0]   first;
   logic [2*n-1:0] dbl_gnt;

   always_comb begin
      dbl_req = {req, req} >> ptr;
      rot     = dbl_req[n-1:0];
      first   = rot & (~rot + {{(n-1){1'b0}}, 1'b1});
      dbl_gnt = {first, first} << ptr;
      gnt     = dbl_gnt[2*n-1:n];
      found   = |req;
   end

endmodule

// File: rtl/mux_n_arb.sv
// N-channel registered selector, fixed or round-robin grant.
// One output register stage with valid/ready on both sides.
module mux_n_arb
   import selector_pkg::*;
#(
   parameter int bus      = 4,
   parameter int channels = 4,
   parameter int sw       = sel_width(channels)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [channels*bus-1:0] d,
   input  logic [channels-1:0]     d_valid,
   output logic [channels-1:0]     d_ready,
   input  logic                    mode,
   input  logic [sw-1:0]           selector,
   output logic [bus-1:0]          out,
   output logic [sw-1:0]           out_id,
   output logic                    out_valid,
   input  logic                    out_ready
);

   logic [bus-1:0]      out_q, out_d;
   logic [sw-1:0]       out_id_q, out_id_d;
   logic                out_valid_q, out_valid_d;
   logic [sw-1:0]       rr_ptr_q, rr_ptr_d;

   logic [channels-1:0] rr_gnt;
   logic                rr_found;
   logic [channels-1:0] fix_gnt;
   logic                fix_hit;
   logic                sel_ok;
   logic [channels-1:0] grant;
   logic                grant_any;
   logic                load_en;
   logic                xfer;
   logic [sw-1:0]       gnt_idx;
   logic [bus-1:0]      gnt_data;

   rr_pick #(
      .n  (channels),
      .pw (sw)
   ) u_rr_pick (
      .req   (d_valid),
      .ptr   (rr_ptr_q),
      .gnt   (rr_gnt),
      .found (rr_found)
   );

   always_comb begin
      sel_ok  = int'(selector) < channels;
      fix_gnt = '0;
      if (sel_ok) begin
         fix_gnt = ({{(channels-1){1'b0}}, 1'b1} << selector)
                 & d_valid;
      end
      fix_hit = |fix_gnt;
   end

   always_comb begin
      load_en   = !out_valid_q || out_ready;
      grant     = (mode == MODE_RR) ? rr_gnt : fix_gnt;
      grant_any = (mode == MODE_RR) ? rr_found : fix_hit;
      xfer      = grant_any && load_en && !rst;
      d_ready   = grant & {channels{xfer}};
   end

   // Grant is one-hot, so OR-reduction encodes index and data.
   always_comb begin
      gnt_idx  = '0;
      gnt_data = '0;
      for (int i = 0; i < channels; i++) begin
         if (grant[i]) begin
            gnt_idx  = gnt_idx | sw'(i);
            gnt_data = gnt_data | d[i*bus +: bus];
         end
      end
   end

   always_comb begin
      out_d       = out_q;
      out_id_d    = out_id_q;
      out_valid_d = out_valid_q;
      rr_ptr_d    = rr_ptr_q;
      if (xfer) begin
         out_d       = gnt_data;
         out_id_d    = gnt_idx;
         out_valid_d = 1'b1;
         if (mode == MODE_RR) begin
            if (int'(gnt_idx) == channels - 1) begin
               rr_ptr_d = '0;
            end else begin
               rr_ptr_d = gnt_idx + sw'(1);
            end
         end
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_q       <= '0;
         out_id_q    <= '0;
         out_valid_q <= 1'b0;
         rr_ptr_q    <= '0;
      end else begin
         out_q       <= out_d;
         out_id_q    <= out_id_d;
         out_valid_q <= out_valid_d;
         rr_ptr_q    <= rr_ptr_d;
      end
   end

   assign out       = out_q;
   assign out_id    = out_id_q;
   assign out_valid = out_valid_q;

endmodule
